// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss fill controller: streams one block of word reads to memory
// and writes the returned words, then the tag, into the cache arrays.
//   state  | meaning
//   IDLE   | no fill; a miss latches the block base and starts a fill
//   WAIT   | issuing block reads and collecting returned words in order
module icache_fill_ctrl #(
  parameter int MEM_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         miss_detected,
  input  logic [15:0]                  miss_address,
  input  logic                         memory_data_valid,
  input  logic [15:0]                  memory_data,
  output logic                         fsm_busy,
  output logic                         mem_read_en,
  output logic [15:0]                  memory_address,
  output logic                         write_data_array,
  output logic [$clog2(MEM_WORDS)-1:0] word_index,
  output logic [15:0]                  cache_data,
  output logic                         write_tag_array
);

  localparam int CW = $clog2(MEM_WORDS);
  localparam logic [0:0]    S_IDLE     = 1'b0;
  localparam logic [0:0]    S_WAIT     = 1'b1;
  localparam logic [CW:0]   ISSUE_END  = (CW+1)'(MEM_WORDS);
  localparam logic [CW-1:0] LAST_WORD  = CW'(MEM_WORDS - 1);
  localparam logic [15:0]   BASE_MASK  = ~16'(2 * MEM_WORDS - 1);

  logic [0:0]    state;
  logic [15:0]   base;
  logic [CW:0]   issue_cnt;
  logic [CW-1:0] recv_cnt;
  logic          issuing;
  logic [CW-1:0] addr_word;

  assign issuing   = (state == S_WAIT) && (issue_cnt < ISSUE_END);
  assign addr_word = issuing ? issue_cnt[CW-1:0] : LAST_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base      <= 16'h0000;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss_detected) begin
            base      <= miss_address & BASE_MASK;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= S_WAIT;
          end
        end
        default: begin
          if (issuing) issue_cnt <= issue_cnt + 1'b1;
          if (memory_data_valid) begin
            recv_cnt <= recv_cnt + 1'b1;
            // A miss on the closing edge is dropped; fetch re-probes next cycle.
            if (recv_cnt == LAST_WORD) state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Busy is qualified by rst_n so the stall releases the moment reset asserts.
  assign fsm_busy         = rst_n && ((state == S_WAIT) || miss_detected);
  assign mem_read_en      = issuing;
  // base has a zero word offset field, so OR-ing the offset can never carry out.
  assign memory_address   = (state == S_WAIT) ?
                            (base | {{(15-CW){1'b0}}, addr_word, 1'b0}) : 16'h0000;
  assign write_data_array = (state == S_WAIT) && memory_data_valid;
  assign word_index       = recv_cnt;
  assign cache_data       = memory_data;
  assign write_tag_array  = write_data_array && (recv_cnt == LAST_WORD);

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: reactive memory with random latency/gaps, a queue-based
// reference model checked every cycle, and directed scenarios with literal pins.
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0000;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = 16'h0000;
  logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, cache_data;
  logic [2:0]  word_index;

  always #5 clk = ~clk;

  icache_fill_ctrl #(.MEM_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .mem_read_en(mem_read_en), .memory_address(memory_address),
    .write_data_array(write_data_array), .word_index(word_index),
    .cache_data(cache_data), .write_tag_array(write_tag_array)
  );

  typedef struct { logic [15:0] data; int due; } resp_t;
  resp_t resp_q[$];
  int lat_min = 4, lat_max = 4;
  bit gap_en = 0, force_valid = 0;
  int cyc = 0;
  int n_pass = 0, n_total = 0;

  // reference model: a fill is a list of addresses still to request plus a word count
  bit          m_active = 0;
  logic [15:0] m_base = 16'h0;
  logic [15:0] m_addr_q[$];
  int          m_recv = 0;

  // per-fill observations of the DUT, compared against hand-computed values
  int start_cyc, req_n, wr_n, first_wr_cyc, tag_cyc, busy_n;
  int first_wr_idx;
  logic [15:0] first_req, last_req;
  bit low_addr_seen;
  int tag_total = 0, wr_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", fsm_busy, 0);
      chk("rst_en", mem_read_en, 0);
      chk("rst_addr", memory_address, 0);
      chk("rst_wda", write_data_array, 0);
      chk("rst_idx", word_index, 0);
      chk("rst_tag", write_tag_array, 0);
      m_active = 0; m_addr_q.delete(); m_recv = 0; resp_q.delete();
    end else begin
      chk("cache_data", cache_data, memory_data);
      if (write_tag_array) begin tag_total++; tag_cyc = cyc; end
      if (write_data_array) begin
        if (wr_n == 0) begin first_wr_cyc = cyc; first_wr_idx = int'(word_index); end
        wr_n++; wr_total++;
      end
      if (!m_active) begin
        chk("idle_busy", fsm_busy, miss_detected);
        chk("idle_en", mem_read_en, 0);
        chk("idle_addr", memory_address, 0);
        chk("idle_wda", write_data_array, 0);
        chk("idle_idx", word_index, 0);
        chk("idle_tag", write_tag_array, 0);
        if (miss_detected) begin
          m_active = 1;
          m_base = miss_address & 16'hFFF0;
          m_addr_q.delete();
          for (int k = 0; k < 8; k++) m_addr_q.push_back(m_base + 16'(2 * k));
          m_recv = 0;
          start_cyc = cyc; req_n = 0; wr_n = 0; busy_n = 1;
          first_wr_cyc = -1; tag_cyc = -1; first_wr_idx = -1; low_addr_seen = 0;
        end
      end else begin
        logic [15:0] e_addr;
        logic        e_en;
        if (m_addr_q.size() > 0) begin e_en = 1; e_addr = m_addr_q.pop_front(); end
        else begin e_en = 0; e_addr = m_base + 16'd14; end
        chk("busy", fsm_busy, 1);
        chk("read_en", mem_read_en, e_en);
        chk("mem_addr", memory_address, e_addr);
        chk("wda", write_data_array, memory_data_valid);
        chk("word_index", word_index, 32'(m_recv % 8));
        chk("tag", write_tag_array, memory_data_valid && m_recv == 7);
        if (fsm_busy) busy_n++;
        if (mem_read_en) begin
          resp_t r;
          r.data = 16'($urandom);
          r.due  = cyc + int'($urandom_range(lat_max, lat_min));
          resp_q.push_back(r);
          if (req_n == 0) first_req = memory_address;
          last_req = memory_address;
          if (memory_address < m_base) low_addr_seen = 1;
          req_n++;
        end
        if (memory_data_valid) begin
          if (m_recv == 7) m_active = 0;
          m_recv++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1; cyc++;
    if (force_valid) begin
      memory_data_valid = 1'b1; memory_data = 16'($urandom);
    end else if (resp_q.size() > 0 && resp_q[0].due <= cyc &&
                 (!gap_en || $urandom_range(2, 0) != 0)) begin
      memory_data_valid = 1'b1; memory_data = resp_q[0].data; void'(resp_q.pop_front());
    end else begin
      memory_data_valid = 1'b0; memory_data = 16'($urandom);
    end
  endtask

  task automatic wait_fill_done(input int budget);
    int k = 0;
    while (m_active && k < budget) begin step(); k++; end
    chk("fill_timeout", m_active, 0);
  endtask

  task automatic do_fill(input logic [15:0] a);
    step(); miss_detected = 1'b1; miss_address = a;
    step(); miss_detected = 1'b0; miss_address = 16'($urandom);
    wait_fill_done(300);
    repeat (2) step();
  endtask

  initial begin
    int tags0, wr0, k;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // nominal fill, latency 4, consecutive valids
    tags0 = tag_total;
    do_fill(16'h1236);
    chk("s1_first_req", first_req, 16'h1230);
    chk("s1_last_req", last_req, 16'h123E);
    chk("s1_req_n", req_n, 8);
    chk("s1_first_wr_cyc", first_wr_cyc - start_cyc, 5);
    chk("s1_tag_cyc", tag_cyc - start_cyc, 12);
    chk("s1_busy_cycles", busy_n, 13);
    chk("s1_tags", tag_total - tags0, 1);

    // top-of-memory block must not wrap
    do_fill(16'hFFFA);
    chk("s2_first_req", first_req, 16'hFFF0);
    chk("s2_last_req", last_req, 16'hFFFE);
    chk("s2_no_wrap", low_addr_seen, 0);

    // gapped, variable-latency returns
    gap_en = 1; lat_min = 1; lat_max = 6; tags0 = tag_total;
    do_fill(16'h5A5F);
    chk("s3_wr_n", wr_n, 8);
    chk("s3_tags", tag_total - tags0, 1);
    chk("s3_first_idx", first_wr_idx, 0);

    // miss held through the fill (including the tag cycle) with a wandering address
    tags0 = tag_total;
    step(); miss_detected = 1'b1; miss_address = 16'h100C;
    step();
    k = 0;
    while (m_active && k < 300) begin miss_address = 16'($urandom); step(); k++; end
    miss_detected = 1'b0;
    chk("s4_timeout", m_active, 0);
    repeat (2) step();
    chk("s4_first_req", first_req, 16'h1000);
    chk("s4_last_req", last_req, 16'h100E);
    chk("s4_tags", tag_total - tags0, 1);

    // reset after the third returned word abandons the fill
    gap_en = 0; lat_min = 4; lat_max = 4; tags0 = tag_total;
    step(); miss_detected = 1'b1; miss_address = 16'h2468;
    step(); miss_detected = 1'b0;
    k = 0;
    while (wr_n < 3 && k < 100) begin step(); k++; end
    chk("s5_three_words", wr_n, 3);
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    repeat (3) step();
    chk("s5_no_tag", tag_total - tags0, 0);
    do_fill(16'h0040);
    chk("s5_first_req", first_req, 16'h0040);
    chk("s5_first_idx", first_wr_idx, 0);
    chk("s5_tags", tag_total - tags0, 1);

    // returned data while idle is ignored
    wr0 = wr_total; tags0 = tag_total;
    force_valid = 1; step(); step(); step(); force_valid = 0; step();
    chk("s6_no_write", wr_total - wr0, 0);
    chk("s6_no_tag", tag_total - tags0, 0);

    // randomized fills
    gap_en = 1; lat_min = 1; lat_max = 8; tags0 = tag_total;
    for (int i = 0; i < 20; i++) begin
      do_fill(16'($urandom));
      repeat ($urandom_range(3, 0)) step();
    end
    chk("rand_tags", tag_total - tags0, 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
